// File: rtl/ep_pkg.sv
// Shared definitions for the dual-port RAM write-side logic: FSM states and
// the address-width calculation used by both the loader and the RAM wrapper.
package ep_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CLEAR,
        DONE
    } state_e;

    function automatic int calcAw(input int kb);
        return $clog2(kb * 1024);
    endfunction

endpackage

// File: rtl/dpr_loader.sv
// Write-side feeder for the dual-port RAM: streams bytes in from a base
// address, or fills the whole RAM with a constant, driving the a2/d2/w2 port.
module dpr_loader
    import ep_pkg::*;
#(
    parameter  int KB = 16,
    localparam int AW = calcAw(KB)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          clear,
    input  logic [AW-1:0] base,
    input  logic [AW:0]   len,
    input  logic [7:0]    fill,
    input  logic          sv,
    input  logic [7:0]    sd,
    output logic          sr,
    output logic [AW-1:0] a2,
    output logic [7:0]    d2,
    output logic          w2,
    output logic          busy,
    output logic          done,
    output logic [7:0]    sum,
    output logic          ovf
);

    localparam logic [AW-1:0] LastAddr = '1;

    state_e        state_q;
    logic [AW-1:0] addr_q;
    logic [AW:0]   rem_q;
    logic [7:0]    sum_q;
    logic          ovf_q;
    logic [7:0]    fill_q;
    logic [AW-1:0] a2_q;
    logic [7:0]    d2_q;
    logic          w2_q;
    logic          done_q;

    logic          accept;
    logic [AW-1:0] addr_d;
    logic [AW:0]   rem_d;
    logic [7:0]    sum_d;

    // Ready depends only on registered state, so sources may drive sv from sr.
    assign sr     = (state_q == LOAD) && (rem_q != '0);
    assign accept = sr && sv;
    assign addr_d = addr_q + 1'b1;
    assign rem_d  = rem_q - 1'b1;
    assign sum_d  = sum_q + sd;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
            fill_q  <= '0;
            a2_q    <= '0;
            d2_q    <= '0;
            w2_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            w2_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (clear) begin
                        state_q <= CLEAR;
                        addr_q  <= '0;
                        fill_q  <= fill;
                    end else if (start) begin
                        state_q <= LOAD;
                        addr_q  <= base;
                        rem_q   <= len;
                        sum_q   <= '0;
                        ovf_q   <= 1'b0;
                    end
                end
                LOAD: begin
                    if (rem_q == '0) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else if (accept) begin
                        w2_q   <= 1'b1;
                        a2_q   <= addr_q;
                        d2_q   <= sd;
                        addr_q <= addr_d;
                        rem_q  <= rem_d;
                        sum_q  <= sum_d;
                        if (addr_q == LastAddr && rem_q > (AW+1)'(1)) begin
                            ovf_q <= 1'b1;
                        end
                        // The final write and the done pulse land in the same cycle.
                        if (rem_q == (AW+1)'(1)) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    w2_q   <= 1'b1;
                    a2_q   <= addr_q;
                    d2_q   <= fill_q;
                    addr_q <= addr_d;
                    if (addr_q == LastAddr) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign a2   = a2_q;
    assign d2   = d2_q;
    assign w2   = w2_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign ovf  = ovf_q;
    assign busy = (state_q == LOAD) || (state_q == CLEAR);

endmodule

// File: tb/tb_dpr_loader.sv
// Scoreboard bench for dpr_loader (KB=1): stimulus pushes expected writes and
// done events; a negedge monitor pops and compares whenever the DUT presents one.
module tb_dpr_loader;

    localparam int KB    = 1;
    localparam int AW    = 10;
    localparam int Depth = 1024;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic          clear;
    logic [AW-1:0] base;
    logic [AW:0]   len;
    logic [7:0]    fill;
    logic          sv;
    logic [7:0]    sd;
    logic          sr;
    logic [AW-1:0] a2;
    logic [7:0]    d2;
    logic          w2;
    logic          busy;
    logic          done;
    logic [7:0]    sum;
    logic          ovf;

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    typedef struct {
        int         cyc;
        logic [7:0] sum;
        logic       ovf;
    } dn_t;

    wr_t        writeQ[$];
    dn_t        doneQ[$];
    logic [7:0] refMem[Depth];
    logic [7:0] dutMem[Depth];
    logic [7:0] loadBytes[16];
    logic [7:0] lastSum = 8'h00;
    logic       lastOvf = 1'b0;
    int         cycle = 0;
    int         checks = 0;
    int         failures = 0;

    dpr_loader #(.KB(KB)) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .clear(clear),
        .base(base),
        .len(len),
        .fill(fill),
        .sv(sv),
        .sd(sd),
        .sr(sr),
        .a2(a2),
        .d2(d2),
        .w2(w2),
        .busy(busy),
        .done(done),
        .sum(sum),
        .ovf(ovf)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    function automatic void pushWrite(input int cyc, input logic [AW-1:0] addr,
                                      input logic [7:0] data, input bit updRef);
        wr_t w;
        w.cyc  = cyc;
        w.addr = addr;
        w.data = data;
        writeQ.push_back(w);
        if (updRef) refMem[addr] = data;
    endfunction

    function automatic void pushDone(input int cyc, input logic [7:0] s, input logic o);
        dn_t d;
        d.cyc = cyc;
        d.sum = s;
        d.ovf = o;
        doneQ.push_back(d);
    endfunction

    // Monitor: every write and every done pulse must match the head of its queue.
    always @(negedge clock) begin
        if (w2 === 1'b1) begin
            if (writeQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected write: a2=%0h d2=%0h, expected no write (cycle %0d)", a2, d2, cycle);
            end else begin
                wr_t e;
                e = writeQ.pop_front();
                checkOutput("write cycle", cycle, e.cyc);
                checkOutput("write addr", 32'(a2), 32'(e.addr));
                checkOutput("write data", 32'(d2), 32'(e.data));
            end
            dutMem[a2] = d2;
        end
        if (done === 1'b1) begin
            if (doneQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected done: got 1, expected 0 (cycle %0d)", cycle);
            end else begin
                dn_t e;
                e = doneQ.pop_front();
                checkOutput("done cycle", cycle, e.cyc);
                checkOutput("done sum", 32'(sum), 32'(e.sum));
                checkOutput("done ovf", 32'(ovf), 32'(e.ovf));
            end
        end
    end

    // Stream load: mode 0 holds sv high, 1 toggles sv, 2 randomizes sv.
    task automatic applyStimulus(input logic [AW-1:0] b, input int n, input int mode);
        int         idx = 0;
        int         guard = 0;
        logic [7:0] s = 8'h00;
        logic       o;
        o = (int'(b) + n) > Depth;
        @(negedge clock);
        start = 1'b1;
        base  = b;
        len   = (AW+1)'(n);
        sv    = 1'b0;
        if (n == 0) pushDone(cycle + 2, 8'h00, 1'b0);
        @(negedge clock);
        start = 1'b0;
        while (idx < n && guard < 400) begin
            guard++;
            case (mode)
                0:       sv = 1'b1;
                1:       sv = (guard % 2) == 1;
                default: sv = 1'($urandom_range(0, 1));
            endcase
            sd = loadBytes[idx];
            checkOutput("sr during load", 32'(sr), 32'd1);
            if (sv) begin
                pushWrite(cycle + 1, b + AW'(idx), loadBytes[idx], 1'b1);
                s = s + loadBytes[idx];
                idx++;
                if (idx == n) pushDone(cycle + 1, s, o);
            end
            @(negedge clock);
        end
        sv = 1'b0;
        if (idx < n) begin
            checks++;
            failures++;
            $display("[TB] FAIL load timeout: accepted %0d, expected %0d", idx, n);
        end
        checkOutput("sr after load", 32'(sr), 32'd0);
        repeat (3) @(negedge clock);
        checkOutput("write queue drained", writeQ.size(), 0);
        checkOutput("done queue drained", doneQ.size(), 0);
        checkOutput("busy after load", 32'(busy), 32'd0);
        lastSum = s;
        lastOvf = o;
    endtask

    // Whole-RAM fill, optionally with a simultaneous start that must be dropped.
    task automatic applyClearStimulus(input logic [7:0] f, input bit withStart);
        int busyCnt = 0;
        int srHigh = 0;
        @(negedge clock);
        clear = 1'b1;
        fill  = f;
        if (withStart) begin
            start = 1'b1;
            base  = AW'($urandom_range(0, Depth - 1));
            len   = (AW+1)'(5);
            sv    = 1'b1;
            sd    = 8'h77;
        end
        for (int k = 0; k < Depth; k++) pushWrite(cycle + 2 + k, AW'(k), f, 1'b1);
        pushDone(cycle + 1 + Depth, lastSum, lastOvf);
        @(negedge clock);
        clear = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 1100 && (doneQ.size() != 0 || writeQ.size() != 0); i++) begin
            if (busy) busyCnt++;
            if (sr) srHigh++;
            @(negedge clock);
        end
        sv = 1'b0;
        checkOutput("clear busy cycles", busyCnt, Depth);
        checkOutput("sr high during clear", srHigh, 0);
        checkOutput("clear writes remaining", writeQ.size(), 0);
        checkOutput("clear done remaining", doneQ.size(), 0);
    endtask

    initial begin
        int  bad;
        bit  found;
        wr_t head;
        reset = 1'b1;
        start = 1'b0;
        clear = 1'b0;
        base  = '0;
        len   = '0;
        fill  = 8'h00;
        sv    = 1'b0;
        sd    = 8'h00;
        for (int i = 0; i < Depth; i++) begin
            refMem[i] = 8'h00;
            dutMem[i] = 8'h00;
        end
        repeat (3) @(negedge clock);
        checkOutput("reset sr", 32'(sr), 0);
        checkOutput("reset w2", 32'(w2), 0);
        checkOutput("reset busy", 32'(busy), 0);
        checkOutput("reset done", 32'(done), 0);
        checkOutput("reset ovf", 32'(ovf), 0);
        checkOutput("reset a2", 32'(a2), 0);
        checkOutput("reset d2", 32'(d2), 0);
        checkOutput("reset sum", 32'(sum), 0);
        reset = 1'b0;

        loadBytes[0] = 8'h11; loadBytes[1] = 8'h22; loadBytes[2] = 8'h33; loadBytes[3] = 8'h44;
        applyStimulus(10'h010, 4, 0);

        loadBytes[0] = 8'h01; loadBytes[1] = 8'h02; loadBytes[2] = 8'h03; loadBytes[3] = 8'h04;
        applyStimulus(10'h3FE, 4, 0);

        loadBytes[0] = 8'hA5; loadBytes[1] = 8'h5A; loadBytes[2] = 8'hFF;
        applyStimulus(10'h123, 3, 1);

        for (int t = 0; t < 5; t++) begin
            for (int i = 0; i < 16; i++) loadBytes[i] = 8'($urandom);
            applyStimulus(AW'($urandom_range(0, Depth - 1)), $urandom_range(1, 16), 2);
        end

        applyStimulus(10'h200, 0, 0);

        applyClearStimulus(8'hE5, 1'b0);

        loadBytes[0] = 8'h80; loadBytes[1] = 8'h90;
        applyStimulus(10'h3FF, 2, 0);
        applyClearStimulus(8'h3C, 1'b1);

        // Abort a fill with reset just as address 0x100 is written.
        @(negedge clock);
        clear = 1'b1;
        fill  = 8'hC3;
        for (int k = 0; k < Depth; k++) pushWrite(cycle + 2 + k, AW'(k), 8'hC3, 1'b0);
        pushDone(cycle + 1 + Depth, lastSum, lastOvf);
        @(negedge clock);
        clear = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(posedge clock);
            #1;
            if (w2 === 1'b1 && a2 == 10'h100) found = 1'b1;
        end
        checkOutput("reached address 0x100", 32'(found), 1);
        reset = 1'b1;
        if (writeQ.size() > 0) begin
            head = writeQ[0];
            writeQ.delete();
            writeQ.push_back(head);
        end
        doneQ.delete();
        for (int a = 0; a <= 'h100; a++) refMem[a] = 8'hC3;
        @(posedge clock);
        #1;
        checkOutput("w2 after abort", 32'(w2), 0);
        checkOutput("busy after abort", 32'(busy), 0);
        checkOutput("sum after abort", 32'(sum), 0);
        checkOutput("ovf after abort", 32'(ovf), 0);
        reset   = 1'b0;
        lastSum = 8'h00;
        lastOvf = 1'b0;
        repeat (5) @(negedge clock);
        checkOutput("abort writes remaining", writeQ.size(), 0);

        loadBytes[0] = 8'h5E; loadBytes[1] = 8'h6F; loadBytes[2] = 8'h70;
        applyStimulus(10'h0FE, 3, 2);

        bad = 0;
        for (int a = 0; a < Depth; a++) if (dutMem[a] !== refMem[a]) bad++;
        checkOutput("ram readback bad entries", bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
